// File: rtl/i2s_tdm_bi.sv
// Bidirectional I2S/TDM serial-audio master: sclk/lrclk generation, NCH-channel tx serialiser and rx deserialiser.
// Optional build macro I2S_TDM_LOOPBACK_EN: rx deserialiser takes the internal sdout instead of the sdin pin.
module i2s_tdm_bi #(
    parameter int unsigned DW       = 24,
    parameter int unsigned SW       = 32,
    parameter int unsigned NCH      = 2,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdout,
    input  logic              sdin,
    input  logic [NCH*DW-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [NCH*DW-1:0] rx_data,
    output logic              rx_valid
);

    localparam int unsigned FW  = NCH * DW;
    localparam int unsigned KW  = (SW > 1) ? $clog2(SW) : 1;
    localparam int unsigned SLW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned DVW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned IW  = (FW > 1) ? $clog2(FW) : 1;

    // Parameter sanity checks at elaboration
    if (SW < DW) begin : g_err_sw
        $error("i2s_tdm_bi: SW must be >= DW");
    end
    if (NCH < 2) begin : g_err_nch
        $error("i2s_tdm_bi: NCH must be >= 2");
    end
    if (SCLK_DIV < 1) begin : g_err_div
        $error("i2s_tdm_bi: SCLK_DIV must be >= 1");
    end

    logic [DVW-1:0] div_q, div_d;
    logic           sclk_q, sclk_d;
    logic           started_q, started_d;
    logic [SLW-1:0] slot_q, slot_d;
    logic [KW-1:0]  k_q, k_d;
    logic           lrclk_q, lrclk_d;
    logic           sdout_q, sdout_d;
    logic           held_q, held_d;
    logic [FW-1:0]  hold_q, hold_d;
    logic [FW-1:0]  tx_sh_q, tx_sh_d;
    logic           underrun_q, underrun_d;
    logic [FW-1:0]  rx_sh_q, rx_sh_d;
    logic [FW-1:0]  rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;

    logic           rx_in;

    // Select the deserialiser source
`ifdef I2S_TDM_LOOPBACK_EN
    logic unused_sdin;
    assign unused_sdin = sdin;
    assign rx_in       = sdout_q;
`else
    assign rx_in       = sdin;
`endif

    // Tick generation, bit counters, tx holding/shift, lrclk and rx capture
    always_comb begin
        logic           wrap;
        logic           fall;
        logic           rise;
        logic           last_bit;
        logic           frame_start;
        logic [SLW-1:0] slot_n;
        logic [KW-1:0]  k_n;
        logic [IW-1:0]  tx_idx;
        logic [IW-1:0]  rx_idx;

        div_d      = div_q;
        sclk_d     = sclk_q;
        started_d  = started_q;
        slot_d     = slot_q;
        k_d        = k_q;
        lrclk_d    = lrclk_q;
        sdout_d    = sdout_q;
        held_d     = held_q;
        hold_d     = hold_q;
        tx_sh_d    = tx_sh_q;
        underrun_d = 1'b0;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        slot_n     = slot_q;
        k_n        = k_q;
        tx_idx     = '0;
        rx_idx     = '0;

        wrap     = (div_q == DVW'(SCLK_DIV - 1));
        fall     = wrap && sclk_q;
        rise     = wrap && !sclk_q;
        last_bit = (slot_q == SLW'(NCH - 1)) && (k_q == KW'(SW - 1));

        div_d = wrap ? '0 : div_q + DVW'(1);
        if (wrap) begin
            sclk_d = ~sclk_q;
        end

        // The first fall tick after reset is bit 0; afterwards advance and wrap
        if (fall) begin
            if (!started_q || last_bit) begin
                slot_n = '0;
                k_n    = '0;
            end else if (k_q == KW'(SW - 1)) begin
                slot_n = slot_q + SLW'(1);
                k_n    = '0;
            end else begin
                k_n    = k_q + KW'(1);
            end
            slot_d    = slot_n;
            k_d       = k_n;
            started_d = 1'b1;
        end
        frame_start = fall && (slot_n == '0) && (k_n == '0);

        // Holding register handshake; a handshake coinciding with a frame load waits a frame
        if (tx_valid && !held_q) begin
            held_d = 1'b1;
            hold_d = tx_data;
        end
        if (frame_start) begin
            if (held_q) begin
                tx_sh_d = hold_q;
                held_d  = 1'b0;
            end else begin
                tx_sh_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Drive data and word select on fall ticks; lrclk leads data by one bit
        if (fall) begin
            if (32'(k_n) < DW) begin
                tx_idx  = IW'(32'(slot_n) * DW + DW - 1 - 32'(k_n));
                sdout_d = tx_sh_d[tx_idx];
            end else begin
                sdout_d = 1'b0;
            end
            if (NCH == 2) begin
                lrclk_d = (k_n == KW'(SW - 1)) ? ~slot_n[0] : slot_n[0];
            end else begin
                lrclk_d = (slot_n == SLW'(NCH - 1)) && (k_n == KW'(SW - 1));
            end
        end

        // Sample on rise ticks; present the frame after its last bit
        if (rise && started_q) begin
            if (32'(k_q) < DW) begin
                rx_idx          = IW'(32'(slot_q) * DW + DW - 1 - 32'(k_q));
                rx_sh_d[rx_idx] = rx_in;
            end
            if (last_bit) begin
                rx_data_d  = rx_sh_d;
                rx_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            sclk_q     <= 1'b0;
            started_q  <= 1'b0;
            slot_q     <= '0;
            k_q        <= '0;
            lrclk_q    <= 1'b0;
            sdout_q    <= 1'b0;
            held_q     <= 1'b0;
            hold_q     <= '0;
            tx_sh_q    <= '0;
            underrun_q <= 1'b0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            started_q  <= started_d;
            slot_q     <= slot_d;
            k_q        <= k_d;
            lrclk_q    <= lrclk_d;
            sdout_q    <= sdout_d;
            held_q     <= held_d;
            hold_q     <= hold_d;
            tx_sh_q    <= tx_sh_d;
            underrun_q <= underrun_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sclk        = sclk_q;
    assign lrclk       = lrclk_q;
    assign sdout       = sdout_q;
    assign tx_ready    = ~held_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_i2s_tdm_bi.sv
// Directed bench for i2s_tdm_bi: I2S (NCH=2) and TDM (NCH=8) instances with sdin tied to sdout.
module tb_i2s_tdm_bi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst2_n, rst8_n;
    logic         sclk2, lrclk2, sdout2, sdin2, tx_valid2, tx_ready2, tx_underrun2, rx_valid2;
    logic [47:0]  tx_data2, rx_data2;
    logic         sclk8, lrclk8, sdout8, sdin8, tx_valid8, tx_ready8, tx_underrun8, rx_valid8;
    logic [127:0] tx_data8, rx_data8;

    assign sdin2 = sdout2;
    assign sdin8 = sdout8;

    i2s_tdm_bi #(.DW(24), .SW(32), .NCH(2), .SCLK_DIV(4)) u_i2s (
        .clk(clk), .rst_n(rst2_n), .sclk(sclk2), .lrclk(lrclk2), .sdout(sdout2), .sdin(sdin2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_underrun(tx_underrun2),
        .rx_data(rx_data2), .rx_valid(rx_valid2)
    );

    i2s_tdm_bi #(.DW(16), .SW(16), .NCH(8), .SCLK_DIV(2)) u_tdm (
        .clk(clk), .rst_n(rst8_n), .sclk(sclk8), .lrclk(lrclk8), .sdout(sdout8), .sdin(sdin8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8), .tx_underrun(tx_underrun8),
        .rx_data(rx_data8), .rx_valid(rx_valid8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [47:0] sent[$];
    logic [47:0] fr;
    logic [63:0] sd_vec, lr_vec;
    int          ucnt, ufirst, ulast, rcnt, rfirst, lcnt, lfirst, nxt, b, f;
    logic        sd_hi, rdy_lo, prev_ready;
    logic [47:0] rx_or;

    initial begin
        rst2_n    = 1'b0;
        rst8_n    = 1'b0;
        tx_valid2 = 1'b0;
        tx_valid8 = 1'b0;
        tx_data2  = '0;
        tx_data8  = '0;
        repeat (3) step();

        // Reset values: {sclk, lrclk, sdout, tx_ready, tx_underrun, rx_valid}
        check("rst_outs_i2s", {sclk2, lrclk2, sdout2, tx_ready2, tx_underrun2, rx_valid2}, 6'b000100);
        check("rst_rxdata_i2s", rx_data2, 0);
        check("rst_outs_tdm", {sclk8, lrclk8, sdout8, tx_ready8, tx_underrun8, rx_valid8}, 6'b000100);

        // No tx traffic: underrun every frame, sdout idle, tx_ready high
        ucnt = 0; ufirst = 0; ulast = 0; rcnt = 0; sd_hi = 0; rdy_lo = 0; rx_or = '0;
        rst2_n = 1'b1;
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            step();
            if (tx_underrun2) begin
                if (ucnt == 0) ufirst = cyc;
                ulast = cyc;
                ucnt++;
            end
            if (sdout2) sd_hi = 1'b1;
            if (!tx_ready2) rdy_lo = 1'b1;
            if (rx_valid2) begin
                rcnt++;
                rx_or |= rx_data2;
            end
        end
        check("udr_count", ucnt, 3);
        check("udr_first", ufirst, 8);
        check("udr_last", ulast, 1032);
        check("udr_sdout_idle", sd_hi, 0);
        check("udr_ready_high", rdy_lo, 0);
        check("udr_rx_count", rcnt, 2);
        check("udr_rx_zero", rx_or, 0);

        // Streaming: first frame {R=5A5A5A, L=A5A5A5}, then distinct frames, tx_valid held high
        rst2_n    = 1'b0;
        tx_valid2 = 1'b1;
        tx_data2  = {24'h5A5A5A, 24'hA5A5A5};
        nxt = 0;
        step();
        prev_ready = tx_ready2;
        rst2_n = 1'b1;
        ucnt = 0; rcnt = 0; rfirst = 0; sd_vec = '0; lr_vec = '0;
        for (int cyc = 1; cyc <= 1560; cyc++) begin
            step();
            if (prev_ready && tx_valid2) begin
                sent.push_back(tx_data2);
                nxt++;
                tx_data2 = {24'(24'h500000 + nxt), 24'(24'hA00000 + nxt)};
            end
            prev_ready = tx_ready2;
            if ((cyc - 9) % 512 == 0) check("ready_after_hs", tx_ready2, 0);
            if (cyc >= 8 && (cyc - 8) % 8 == 0) begin
                b = ((cyc - 8) / 8) % 64;
                f = (cyc - 8) / 512;
                if (b == 0) check("ready_at_b0", tx_ready2, 1);
                sd_vec[63 - b] = sdout2;
                lr_vec[63 - b] = lrclk2;
                if (b == 63 && f < sent.size()) begin
                    fr = sent[f];
                    check("sdout_frame", sd_vec, {fr[23:0], 8'h00, fr[47:24], 8'h00});
                    // lrclk high for bits 31..62 of the frame
                    check("lrclk_frame", lr_vec, 64'h0000_0001_FFFF_FFFE);
                end
            end
            if (tx_underrun2) ucnt++;
            if (rx_valid2) begin
                if (rcnt == 0) rfirst = cyc;
                if (rcnt < sent.size()) check("rx_frame_i2s", rx_data2, sent[rcnt]);
                rcnt++;
            end
        end
        check("stream_no_underrun", ucnt, 0);
        check("stream_rx_first", rfirst, 516);
        check("stream_rx_count", rcnt, 3);

        // TDM: ch c = 16'h1000+c, frame sync once per frame during slot7 LSB
        for (int c = 0; c < 8; c++) tx_data8[c*16 +: 16] = 16'(16'h1000 + c);
        tx_valid8 = 1'b1;
        rst8_n = 1'b1;
        lcnt = 0; lfirst = 0; ucnt = 0; rcnt = 0; rfirst = 0;
        for (int cyc = 1; cyc <= 1030; cyc++) begin
            step();
            if (lrclk8) begin
                if (lcnt == 0) lfirst = cyc;
                lcnt++;
            end
            if (tx_underrun8) ucnt++;
            if (rx_valid8) begin
                if (rcnt == 0) rfirst = cyc;
                check("rx_frame_tdm", rx_data8, tx_data8);
                rcnt++;
            end
        end
        check("tdm_fsync_cycles", lcnt, 8);
        check("tdm_fsync_first", lfirst, 512);
        check("tdm_rx_first", rfirst, 514);
        check("tdm_rx_count", rcnt, 2);
        check("tdm_no_underrun", ucnt, 0);

        // Reset for one clk in the middle of slot 3
        rst8_n = 1'b0;
        step();
        rst8_n = 1'b1;
        rcnt = 0;
        for (int cyc = 1; cyc <= 228; cyc++) begin
            step();
            if (rx_valid8) rcnt++;
        end
        rst8_n = 1'b0;
        step();
        check("midrst_outs", {sclk8, lrclk8, sdout8, tx_ready8, tx_underrun8, rx_valid8}, 6'b000100);
        check("midrst_rxdata", rx_data8, 0);
        rst8_n = 1'b1;
        rfirst = 0; ucnt = 0;
        for (int cyc = 1; cyc <= 520; cyc++) begin
            step();
            if (tx_underrun8) ucnt++;
            if (rx_valid8) begin
                if (rfirst == 0) rfirst = cyc;
                check("midrst_rx_frame", rx_data8, tx_data8);
                rcnt++;
            end
        end
        check("midrst_rx_count", rcnt, 1);
        check("midrst_rx_first", rfirst, 514);
        check("midrst_no_underrun", ucnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
